// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp controller for the pwm block: accepts a target over valid/ready
// and fades 'value' toward it by at most STEP every TICK_DIV clocks.
module pwm_ramp_ctrl #(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned MAX_VALUE = 8,
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned STEP      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_VALUE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             ready_q, busy_q, done_q;

  logic [WIDTH-1:0] clamped;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step_amt;
  logic [WIDTH-1:0] moved;
  logic             going_up;
  logic             tick;

  // Step arithmetic: move by min(STEP, |tgt - value|), so no overshoot or wrap.
  always_comb begin
    clamped  = (target > MAX_W) ? MAX_W : target;
    going_up = (tgt_q >= value_q);
    diff     = going_up ? (tgt_q - value_q) : (value_q - tgt_q);
    step_amt = (32'(diff) < STEP) ? diff : WIDTH'(STEP);
    moved    = going_up ? (value_q + step_amt) : (value_q - step_amt);
    tick     = (presc_q == TICK_LAST);
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    tgt_d   = tgt_q;
    presc_d = presc_q;
    case (state_q)
      S_IDLE: begin
        if (target_valid) begin
          tgt_d   = clamped;
          presc_d = '0;
          state_d = (clamped != value_q) ? S_RAMP : S_FINISH;
        end
      end
      S_RAMP: begin
        if (tick) begin
          presc_d = '0;
          value_d = moved;
          if (moved == tgt_q) begin
            state_d = S_FINISH;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      value_q <= '0;
      tgt_q   <= '0;
      presc_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      tgt_q   <= tgt_d;
      presc_q <= presc_d;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FINISH);
    end
  end

  assign target_ready = ready_q;
  assign value        = value_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: two instances (STEP=1 and STEP=2, TICK_DIV=4)
// checked against a step-by-step arithmetic model of the ramp.
module tb_pwm_ramp_ctrl;
  localparam int unsigned W     = 9;
  localparam int unsigned MAXV  = 8;
  localparam int unsigned TD    = 4;
  localparam int unsigned STEP0 = 1;
  localparam int unsigned STEP1 = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] tgt  [2];
  logic         tv   [2];
  logic         tr   [2];
  logic         busy [2];
  logic         done [2];
  logic [W-1:0] val  [2];

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.WIDTH(W), .MAX_VALUE(MAXV), .TICK_DIV(TD), .STEP(STEP0)) dut0 (
    .clk(clk), .rst(rst), .target(tgt[0]), .target_valid(tv[0]),
    .target_ready(tr[0]), .value(val[0]), .busy(busy[0]), .done(done[0]));

  pwm_ramp_ctrl #(.WIDTH(W), .MAX_VALUE(MAXV), .TICK_DIV(TD), .STEP(STEP1)) dut1 (
    .clk(clk), .rst(rst), .target(tgt[1]), .target_valid(tv[1]),
    .target_ready(tr[1]), .value(val[1]), .busy(busy[1]), .done(done[1]));

  typedef struct {
    bit          is_done;
    int unsigned v;
    int unsigned cyc;
  } ev_t;

  ev_t         exp_q [2][$];
  int unsigned mv [2];
  int unsigned last_v [2];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: expected value change events and the done pulse for one accept at edge k.
  function automatic void plan(input int i, input int unsigned t, input int unsigned k);
    int unsigned tc = (t > MAXV) ? MAXV : t;
    int unsigned st = (i == 0) ? STEP0 : STEP1;
    int unsigned v  = mv[i];
    int unsigned n  = 0;
    ev_t e;
    while (v != tc) begin
      n++;
      if (v < tc) v = (tc - v > st) ? v + st : tc;
      else        v = (v - tc > st) ? v - st : tc;
      e.is_done = 1'b0; e.v = v; e.cyc = k + n * TD;
      exp_q[i].push_back(e);
    end
    e.is_done = 1'b1; e.v = tc; e.cyc = k + n * TD;
    exp_q[i].push_back(e);
    mv[i] = tc;
  endfunction

  task automatic pop_cmp(input int i, input bit is_done);
    ev_t e;
    string tag = is_done ? "done" : "value_change";
    if (exp_q[i].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL inst%0d unexpected %s: value=%0d cycle=%0d, required no event",
               i, tag, val[i], cyc);
    end else begin
      e = exp_q[i].pop_front();
      check($sformatf("inst%0d %s kind", i, tag), 32'(is_done), 32'(e.is_done));
      check($sformatf("inst%0d %s value", i, tag), 32'(val[i]), e.v);
      check($sformatf("inst%0d %s cycle", i, tag), cyc, e.cyc);
    end
  endtask

  // Monitor: every value change and every done cycle must match the next queued event.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        last_v[i] = 32'(val[i]);
      end else begin
        check($sformatf("inst%0d value<=max", i), 32'(val[i] <= W'(MAXV)), 1);
        if (32'(val[i]) != last_v[i]) pop_cmp(i, 1'b0);
        if (done[i]) pop_cmp(i, 1'b1);
        check($sformatf("inst%0d ready==!busy", i), 32'(tr[i]), 32'(!busy[i]));
        last_v[i] = 32'(val[i]);
      end
    end
  end

  task automatic wait_idle(input int i);
    int n = 0;
    while (exp_q[i].size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL inst%0d ramp timeout: %0d events pending, required 0", i, exp_q[i].size());
      exp_q[i].delete();
    end
  endtask

  task automatic issue(input int i, input int unsigned t, input bit wait_done);
    int n = 0;
    @(negedge clk);
    while (!(tr[i] && exp_q[i].size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL inst%0d ready timeout: ready=%0d, required 1", i, tr[i]);
    end
    tgt[i] = W'(t);
    tv[i]  = 1'b1;
    plan(i, t, cyc + 1);
    @(posedge clk);
    #1 tv[i] = 1'b0;
    if (wait_done) wait_idle(i);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s inst%0d value", tag, i), 32'(val[i]), 0);
      check($sformatf("%s inst%0d ready", tag, i), 32'(tr[i]), 1);
      check($sformatf("%s inst%0d busy", tag, i), 32'(busy[i]), 0);
      check($sformatf("%s inst%0d done", tag, i), 32'(done[i]), 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global timeout at cycle %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned t;
    int          i;
    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tgt[j] = '0; tv[j] = 1'b0; mv[j] = 0; last_v[j] = 0;
    end
    #1 check_reset_state("power_on_reset");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    issue(0, 5, 1'b1);      // 0 -> 5 one step per 4 clocks
    issue(0, 300, 1'b1);    // clamped to 8
    issue(0, 8, 1'b1);      // equal target: immediate done
    issue(0, 3, 1'b1);

    // Mid-ramp target with valid held must be ignored.
    issue(0, 6, 1'b0);
    repeat (2) @(negedge clk);
    tgt[0] = W'(1);
    tv[0]  = 1'b1;
    repeat (5) @(negedge clk);
    tv[0]  = 1'b0;
    wait_idle(0);

    issue(1, 5, 1'b1);
    issue(1, 2, 1'b1);      // STEP=2: 5 -> 3 -> 2, no overshoot
    issue(1, 2, 1'b1);

    for (int n = 0; n < 12; n++) begin
      i = int'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       t = mv[i];
        1:       t = $urandom_range(9, 511);
        default: t = $urandom_range(0, 8);
      endcase
      issue(i, t, 1'b1);
    end

    // Asynchronous reset in the middle of a ramp, checked before any clock edge.
    issue(1, (mv[1] > 4) ? 0 : 8, 1'b0);
    repeat (5) @(posedge clk);
    #2 check("inst1 busy before reset", 32'(busy[1]), 1);
    rst = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    mv[0] = 0;
    mv[1] = 0;
    #1 check_reset_state("mid_ramp_reset");
    @(negedge clk);
    #1 rst = 1'b0;

    issue(0, 2, 1'b1);
    issue(1, 7, 1'b1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
